// File: rtl/proc_mem_responder_if.sv
// rtl/proc_mem_responder_if.sv - instruction/data memory request/response bundle
// The core drives the request fields (master); the responder returns data (slave).
interface proc_mem_responder_if;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;

  modport master (
    output imemreq_val, imemreq_addr,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  imemresp_data, dmemresp_rdata
  );

  modport slave (
    input  imemreq_val, imemreq_addr,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output imemresp_data, dmemresp_rdata
  );
endinterface

// File: rtl/proc_mem_responder.sv
// rtl/proc_mem_responder.sv - TinyRV1 imem/dmem responder with one-entry store buffer
// Optional access counters are built when MEM_STATS_EN is defined.
module proc_mem_responder #(
  parameter int unsigned WORDS = 256,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  proc_mem_responder_if.slave    mem,
  input  logic                   init_en,
  input  logic [31:0]            init_addr,
  input  logic [31:0]            init_data,
  output logic                   err,
  output logic [31:0]            err_addr
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]            stat_ifetch,
  output logic [31:0]            stat_load,
  output logic [31:0]            stat_store
`endif
);

  localparam int unsigned AW   = $clog2(WORDS);
  localparam logic [31:0] SPAN = 32'(4 * WORDS);

  logic [31:0]   array [WORDS];

  logic          sb_val;
  logic [AW-1:0] sb_idx;
  logic [31:0]   sb_data;

  logic [31:0]   i_off, d_off, n_off;
  logic          i_ok, d_ok, n_ok;
  logic [AW-1:0] i_idx, d_idx, n_idx;

  // Offsets from BASE; BASE is span-aligned so offset[1:0] equals addr[1:0].
  assign i_off = mem.imemreq_addr - BASE;
  assign d_off = mem.dmemreq_addr - BASE;
  assign n_off = init_addr - BASE;

  assign i_ok  = (i_off[1:0] == 2'b00) && (i_off < SPAN);
  assign d_ok  = (d_off[1:0] == 2'b00) && (d_off < SPAN);
  assign n_ok  = (n_off[1:0] == 2'b00) && (n_off < SPAN);

  assign i_idx = i_off[AW+1:2];
  assign d_idx = d_off[AW+1:2];
  assign n_idx = n_off[AW+1:2];

  logic store_ok, load_ok, fetch_ok;
  logic i_bad, d_bad;
  logic init_wr, init_hit, commit;

  assign store_ok = mem.dmemreq_val &&  mem.dmemreq_type && d_ok;
  assign load_ok  = mem.dmemreq_val && !mem.dmemreq_type && d_ok;
  assign fetch_ok = mem.imemreq_val && i_ok;
  assign i_bad    = mem.imemreq_val && !i_ok;
  assign d_bad    = mem.dmemreq_val && !d_ok;

  // A backdoor write to the buffered index supersedes the buffered store.
  assign init_wr  = init_en && n_ok;
  assign init_hit = init_wr && sb_val && (n_idx == sb_idx);
  assign commit   = sb_val && !rst && !init_hit;

  always_ff @(posedge clk) begin
    if (commit)
      array[sb_idx] <= sb_data;
    if (init_wr)
      array[n_idx] <= init_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_val  <= 1'b0;
      sb_idx  <= '0;
      sb_data <= '0;
    end else if (store_ok) begin
      sb_val  <= 1'b1;
      sb_idx  <= d_idx;
      sb_data <= mem.dmemreq_wdata;
    end else begin
      sb_val  <= 1'b0;
    end
  end

  always_comb begin
    mem.imemresp_data = '0;
    if (i_ok)
      mem.imemresp_data = (sb_val && sb_idx == i_idx) ? sb_data : array[i_idx];
  end

  always_comb begin
    mem.dmemresp_rdata = '0;
    if (d_ok)
      mem.dmemresp_rdata = (sb_val && sb_idx == d_idx) ? sb_data : array[d_idx];
  end

  // First bad address wins; dmem is reported ahead of imem on a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (i_bad || d_bad) begin
      err <= 1'b1;
      if (!err)
        err_addr <= d_bad ? mem.dmemreq_addr : mem.imemreq_addr;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ifetch <= '0;
      stat_load   <= '0;
      stat_store  <= '0;
    end else begin
      if (fetch_ok) stat_ifetch <= stat_ifetch + 32'd1;
      if (load_ok)  stat_load   <= stat_load   + 32'd1;
      if (store_ok) stat_store  <= stat_store  + 32'd1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, fetch_ok, load_ok};
`endif

endmodule

// File: tb/tb_proc_mem_responder.sv
// tb/tb_proc_mem_responder.sv - directed self-checking bench for proc_mem_responder
module tb_proc_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        init_en;
  logic [31:0] init_addr, init_data;
  logic        err;
  logic [31:0] err_addr;
`ifdef MEM_STATS_EN
  logic [31:0] stat_ifetch, stat_load, stat_store;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  proc_mem_responder_if bus ();

  proc_mem_responder #(.WORDS(256), .BASE(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus.slave),
    .init_en   (init_en),
    .init_addr (init_addr),
    .init_data (init_data),
    .err       (err),
    .err_addr  (err_addr)
`ifdef MEM_STATS_EN
    ,
    .stat_ifetch (stat_ifetch),
    .stat_load   (stat_load),
    .stat_store  (stat_store)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imemreq_val   = 1'b0;
    bus.imemreq_addr  = 32'h0;
    bus.dmemreq_val   = 1'b0;
    bus.dmemreq_type  = 1'b0;
    bus.dmemreq_addr  = 32'h0;
    bus.dmemreq_wdata = 32'h0;
    init_en   = 1'b0;
    init_addr = 32'h0;
    init_data = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = a;
  endtask

  task automatic load(input logic [31:0] a);
    bus.dmemreq_val  = 1'b1;
    bus.dmemreq_type = 1'b0;
    bus.dmemreq_addr = a;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.dmemreq_val   = 1'b1;
    bus.dmemreq_type  = 1'b1;
    bus.dmemreq_addr  = a;
    bus.dmemreq_wdata = d;
  endtask

  task automatic init_wr(input logic [31:0] a, input logic [31:0] d);
    init_en   = 1'b1;
    init_addr = a;
    init_data = d;
  endtask

  initial begin
    logic [31:0] seed [6];
    seed[0] = 32'h11; seed[1] = 32'h22; seed[2] = 32'h33;
    seed[3] = 32'h44; seed[4] = 32'h55; seed[5] = 32'h66;

    idle();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      idle(); init_wr(32'(i * 4), seed[i]); tick();
    end
    idle(); init_wr(32'h24, 32'h99); tick();
    idle(); init_wr(32'h40, 32'h0); tick();
    idle(); rst = 1'b0;

    // Reset state and plain fetch
    fetch(32'h8);
    bus.dmemreq_addr = 32'h0;
    #1;
    check_eq("rst_err", {31'b0, err}, 32'h0);
    check_eq("rst_err_addr", err_addr, 32'h0);
    check_eq("fetch_8", bus.imemresp_data, 32'h33);
    check_eq("rdata_no_val", bus.dmemresp_rdata, 32'h11);
`ifdef MEM_STATS_EN
    check_eq("rst_stat_ifetch", stat_ifetch, 32'h0);
`endif
    tick();

    // Store then load forwarding, then array commit
    idle(); store(32'h40, 32'hDEADBEEF); tick();
    idle(); load(32'h40); #1;
    check_eq("fwd_40", bus.dmemresp_rdata, 32'hDEADBEEF);
    tick();
    idle(); load(32'h40); #1;
    check_eq("array_40", bus.dmemresp_rdata, 32'hDEADBEEF);
    tick();

    // Back-to-back stores with imem tracking 0x10
    idle(); store(32'h10, 32'h1); fetch(32'h10); #1;
    check_eq("b2b_i0", bus.imemresp_data, 32'h55);
    tick();
    idle(); store(32'h14, 32'h2); fetch(32'h10); #1;
    check_eq("b2b_i1", bus.imemresp_data, 32'h1);
    tick();
    idle(); store(32'h10, 32'h3); fetch(32'h10); #1;
    check_eq("b2b_i2", bus.imemresp_data, 32'h1);
    tick();
    idle(); load(32'h14); fetch(32'h10); #1;
    check_eq("b2b_i3", bus.imemresp_data, 32'h3);
    check_eq("b2b_ld14", bus.dmemresp_rdata, 32'h2);
    tick();
    idle(); load(32'h10); fetch(32'h14); #1;
    check_eq("b2b_ld10", bus.dmemresp_rdata, 32'h3);
    check_eq("b2b_i14", bus.imemresp_data, 32'h2);
    tick();

    // Top word is valid; misaligned and out-of-range are not
    idle(); store(32'h3FC, 32'hABCD); tick();
    idle(); load(32'h42); #1;
    check_eq("bad_rdata", bus.dmemresp_rdata, 32'h0);
    check_eq("top_no_err", {31'b0, err}, 32'h0);
    tick();
    check_eq("bad_err", {31'b0, err}, 32'h1);
    check_eq("bad_err_addr", err_addr, 32'h42);
    idle(); store(32'h400, 32'h77); #1;
    check_eq("oob_rdata", bus.dmemresp_rdata, 32'h0);
    tick();
    idle(); load(32'h3FC); #1;
    check_eq("err_addr_sticky", err_addr, 32'h42);
    check_eq("top_word", bus.dmemresp_rdata, 32'hABCD);
    tick();
    idle(); rst = 1'b1; tick();
    rst = 1'b0; #1;
    check_eq("rst_clr_err", {31'b0, err}, 32'h0);
    check_eq("rst_clr_addr", err_addr, 32'h0);

    // Simultaneous bad imem and dmem: dmem address recorded
    idle(); fetch(32'h1001); load(32'h2); tick();
    check_eq("prio_err_addr", err_addr, 32'h2);
    idle(); rst = 1'b1; tick();
    rst = 1'b0;

    // Init hits buffered index: init wins
    idle(); store(32'h20, 32'h5); tick();
    idle(); init_wr(32'h20, 32'h9); tick();
    idle(); load(32'h20); #1;
    check_eq("init_wins", bus.dmemresp_rdata, 32'h9);
    tick();

    // Same-cycle store and init to one index: store wins
    idle(); store(32'h28, 32'h6); init_wr(32'h28, 32'h1); tick();
    idle(); load(32'h28); #1;
    check_eq("store_wins_fwd", bus.dmemresp_rdata, 32'h6);
    tick();
    idle(); fetch(32'h28); #1;
    check_eq("store_wins_arr", bus.imemresp_data, 32'h6);
    tick();

    // Invalid init address ignored and raises no error
    idle(); init_wr(32'h21, 32'hFF); tick();
    check_eq("bad_init_no_err", {31'b0, err}, 32'h0);

    // Pending store dropped by reset
    idle(); store(32'h24, 32'h7); tick();
    idle(); rst = 1'b1; tick();
    idle(); rst = 1'b0; load(32'h24); #1;
    check_eq("rst_drops_sb", bus.dmemresp_rdata, 32'h99);
    tick();

    // Access counters: 3 fetches, 2 loads, 1 store, 1 bad load
    idle(); rst = 1'b1; tick();
    idle(); rst = 1'b0; fetch(32'h0); load(32'h4); tick();
    idle(); fetch(32'h8); load(32'hC); tick();
    idle(); fetch(32'hC); store(32'h30, 32'h1); tick();
    idle(); load(32'h402); tick();
    idle(); tick();
`ifdef MEM_STATS_EN
    check_eq("stat_ifetch", stat_ifetch, 32'd3);
    check_eq("stat_load", stat_load, 32'd2);
    check_eq("stat_store", stat_store, 32'd1);
`endif
    check_eq("stat_bad_err", {31'b0, err}, 32'h1);
    check_eq("stat_bad_addr", err_addr, 32'h402);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Responder end of the processor's instruction/data memory interface.
- Services `imemreq`/`dmemreq` from the pipelined TinyRV1 core with same-cycle (combinational) read data.
- Stores are absorbed through a one-entry store buffer and committed to the word array one cycle later. Reads forward from that buffer.
- Also provides a backdoor init port for the test bench, sticky error detection for bad addresses, and optional access counters.

Parameters:
- WORDS, 256, number of 32-bit words in the array; power of two, 16..65536.
- BASE, 32'h00000000, byte address of word 0; must be aligned to 4*WORDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- imemreq_val  input  1  instruction fetch request valid.
- imemreq_addr  input  32  fetch byte address.
- imemresp_data  output  32  fetch data, combinational.
- dmemreq_val  input  1  data request valid.
- dmemreq_type  input  1  0 = load, 1 = store.
- dmemreq_addr  input  32  data byte address.
- dmemreq_wdata  input  32  store data.
- dmemresp_rdata  output  32  load data, combinational.
- init_en  input  1  backdoor word write enable.
- init_addr  input  32  backdoor byte address.
- init_data  input  32  backdoor write data.
- err  output  1  sticky bad-address flag.
- err_addr  output  32  address of first bad access.

Behaviour:
- Clock and reset: one clock domain (clk); reset rst is synchronous, active-high.
- Address check: an address is valid iff addr[1:0]==0 and (addr-BASE) < 4*WORDS. Word index = (addr-BASE)[log2(WORDS)+1:2].
- Reset clears sb_val, err, err_addr=0 and counters. The array is NOT reset. After reset both response outputs reflect array contents.
- Store buffer state: sb_val, sb_idx, sb_data.
- Store handling: a valid store (dmemreq_val & type=1 & valid addr) loads sb_idx/sb_data and sets sb_val at the edge. In the same edge, any previously buffered entry is written to the array.
- Buffer drain: with no new store, a pending entry commits and sb_val clears. Back-to-back stores every cycle are legal; there is no stall and no ready signal.
- Read data: imemresp_data/dmemresp_rdata = sb_data if sb_val and index matches, else array[index].
  - Forwarding therefore makes a store visible to a load in the very next cycle.
  - A store and load in the same cycle is impossible on the single dmem port.
  - Data is returned regardless of `*_val`. Output is 0 when the address is invalid.
- Bad addresses:
  - Any `*_val` request with an invalid address sets err at the edge.
  - If err was 0, err_addr captures the address, with dmem taking priority over imem when both are bad.
  - A bad store is dropped and does not disturb the buffer.
  - err holds until rst.
- Backdoor init: init_en with a valid address writes the array directly at the edge.
  - If sb_val matches the same index, the buffered entry is discarded (init wins).
  - If a new store targets the same index in the same cycle, the new store wins, because it is buffered and commits later.
  - An invalid init address is ignored; it does not set err.
- Reset mid-operation: a pending sb entry is discarded (not committed).

Optional Feature:
- MEM_STATS_EN defined: adds outputs stat_ifetch, stat_load, stat_store (each 32 bit).
  - Each counts accepted valid-address requests of that kind.
  - Counters reset to 0 and wrap at 2^32.
  - Bad-address requests are not counted.
- Not defined: no counter ports and no counter logic.

Test Plan:
- Init and fetch: init words 0..3 via backdoor with 32'h11,22,33,44; reset; imemreq_addr=8 -> imemresp_data=32'h33, err=0.
- Store-load forwarding: store 32'hDEADBEEF to addr 0x40; next cycle load 0x40 -> 32'hDEADBEEF via buffer; two cycles later, array word 16 holds 32'hDEADBEEF.
- Back-to-back stores: store 0x10<-1, 0x14<-2, 0x10<-3 on consecutive cycles, then idle; loads of 0x10 and 0x14 return 3 and 2; imem reads of 0x10 on each cycle track the latest value.
- Bad addresses: load at 0x42 -> rdata=0, err=1, err_addr=0x42; later store at 4*WORDS+BASE -> dropped, err_addr stays 0x42; rst clears both.
- Init/buffer collision: store 0x20<-5, then same cycle init 0x20<-9 -> load 0x20 returns 9; reset with sb pending (store 0x24<-7 then rst) -> word 9 unchanged.
- MEM_STATS_EN: 3 fetches, 2 loads, 1 store, 1 bad load -> stat_ifetch=3, stat_load=2, stat_store=1.
